// File: rtl/aes_block_packer.sv
// aes_block_packer: packs a byte stream into 128-bit AES blocks with PKCS#7 padding and core handshake
module aes_block_packer (
   input  logic         clk,
   input  logic         reset,
   input  logic [7:0]   s_data,
   input  logic         s_valid,
   input  logic         s_last,
   output logic         s_ready,
   input  logic         encrypt,
   input  logic [127:0] key,
   input  logic         key_load,
   output logic [127:0] aes_in,
   output logic [127:0] aes_key,
   output logic         aes_encrypt,
   output logic         aes_ready,
   input  logic         aes_done,
   output logic         msg_done,
   output logic         pad_err,
   output logic [15:0]  blk_count
);
   typedef enum logic [1:0] {FILL, ISSUE, WAIT, PADBLK} state_t;
   state_t         r_state;
   logic [3:0]     r_cnt;
   logic           r_som;
   logic           r_pad_pending;
   logic           r_last_blk;
   logic [127:0]   r_blk;
   logic [127:0]   r_key;
   logic           r_enc;
   logic           r_ready;
   logic           r_msg_done;
   logic           r_pad_err;
   logic [15:0]    r_blk_count;
   logic           w_accept;
   logic           w_enc;
   logic           w_full;
   logic           w_close;
   logic [7:0]     w_pad;
   logic [15:0]    w_base;
   logic [127:0]   w_blk;
   assign s_ready     = (r_state == FILL) & ~reset;
   assign w_accept    = s_valid & s_ready;
   assign w_enc       = r_som ? encrypt : r_enc;
   assign w_full      = r_cnt == 4'd15;
   assign w_close     = w_accept & (s_last | w_full);
   assign w_pad       = w_enc ? 8'd15 - {4'd0, r_cnt} : 8'd0;
   assign w_base      = r_som ? 16'd0 : r_blk_count;
   assign aes_in      = r_blk;
   assign aes_key     = r_key;
   assign aes_encrypt = r_enc;
   assign aes_ready   = r_ready;
   assign msg_done    = r_msg_done;
   assign pad_err     = r_pad_err;
   assign blk_count   = r_blk_count;
   // Next block image: incoming byte at slot cnt, pad fill behind it when the message ends here
   always_comb begin
      w_blk = r_blk;
      for (int i = 0; i < 16; i++)
         if (4'(i) == r_cnt) w_blk[127-8*i -: 8] = s_data;
         else if (4'(i) > r_cnt && s_last) w_blk[127-8*i -: 8] = w_pad;
   end
   // Control FSM: fill, issue strobe, wait for core, optional trailing pad block
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state       <= FILL;
         r_cnt         <= 4'd0;
         r_som         <= 1'b1;
         r_pad_pending <= 1'b0;
         r_last_blk    <= 1'b0;
         r_blk         <= '0;
         r_key         <= '0;
         r_enc         <= 1'b0;
         r_ready       <= 1'b0;
         r_msg_done    <= 1'b0;
         r_pad_err     <= 1'b0;
         r_blk_count   <= 16'd0;
      end else begin
         r_ready    <= 1'b0;
         r_msg_done <= 1'b0;
         r_pad_err  <= 1'b0;
         case (r_state)
            FILL: begin
               if (key_load && r_cnt == 4'd0 && r_som) r_key <= key;
               if (w_accept) begin
                  r_blk <= w_blk;
                  r_cnt <= w_close ? 4'd0 : r_cnt + 4'd1;
                  r_som <= 1'b0;
                  if (r_som) r_enc <= encrypt;
                  if (w_close) begin
                     r_state       <= ISSUE;
                     r_ready       <= 1'b1;
                     r_blk_count   <= w_base + 16'd1;
                     r_last_blk    <= s_last & ~(w_enc & w_full);
                     r_pad_pending <= s_last & w_enc & w_full;
                     r_pad_err     <= s_last & ~w_enc & ~w_full;
                  end else if (r_som) r_blk_count <= 16'd0;
               end
            end
            ISSUE: r_state <= WAIT;
            WAIT: begin
               if (aes_done) begin
                  r_state    <= r_pad_pending ? PADBLK : FILL;
                  r_msg_done <= ~r_pad_pending & r_last_blk;
                  r_som      <= ~r_pad_pending & r_last_blk;
               end
            end
            PADBLK: begin
               r_blk         <= {16{8'h10}};
               r_pad_pending <= 1'b0;
               r_last_blk    <= 1'b1;
               r_ready       <= 1'b1;
               r_blk_count   <= r_blk_count + 16'd1;
               r_state       <= ISSUE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_aes_block_packer.sv
// tb_aes_block_packer: randomized scoreboard bench for aes_block_packer
module tb_aes_block_packer;
   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic [7:0]   s_data = 8'h00;
   logic         s_valid = 1'b0;
   logic         s_last = 1'b0;
   logic         s_ready;
   logic         encrypt = 1'b0;
   logic [127:0] key = '0;
   logic         key_load = 1'b0;
   logic [127:0] aes_in;
   logic [127:0] aes_key;
   logic         aes_encrypt;
   logic         aes_ready;
   logic         aes_done = 1'b0;
   logic         msg_done;
   logic         pad_err;
   logic [15:0]  blk_count;

   aes_block_packer dut (
      .clk(clk), .reset(reset), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
      .s_ready(s_ready), .encrypt(encrypt), .key(key), .key_load(key_load),
      .aes_in(aes_in), .aes_key(aes_key), .aes_encrypt(aes_encrypt), .aes_ready(aes_ready),
      .aes_done(aes_done), .msg_done(msg_done), .pad_err(pad_err), .blk_count(blk_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [127:0] blk;
      logic [127:0] k;
      logic         enc;
      logic [15:0]  cnt;
      logic         perr;
      logic         last;
   } exp_t;

   exp_t         exp_q[$];
   logic [7:0]   msg[$];
   int           checks = 0;
   int           failures = 0;
   int           md_cnt = 0;
   int           md_exp = 0;
   int           core_lat = 2;
   bit           busy = 0;
   bit           expect_md = 0;
   bit           core_auto = 1;
   logic [127:0] mkey = '0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   // Monitor: pops the scoreboard on every issued block and polices handshake rules
   initial forever begin
      exp_t e;
      @(negedge clk);
      if (!reset) begin
         if (busy) chk("s_ready_low_in_wait", s_ready, 0);
         if (aes_done) busy = 0;
         if (aes_ready) begin
            busy = 1;
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_block actual=%h required=none", aes_in);
            end else begin
               e = exp_q.pop_front();
               chk("aes_in", aes_in, e.blk);
               chk("aes_key", aes_key, e.k);
               chk("aes_encrypt", aes_encrypt, e.enc);
               chk("blk_count", blk_count, e.cnt);
               chk("pad_err", pad_err, e.perr);
               if (e.last) expect_md = 1;
            end
         end else if (pad_err) chk("pad_err_stray", pad_err, 0);
         if (msg_done) begin
            chk("msg_done_expected", expect_md, 1);
            expect_md = 0;
            md_cnt++;
         end
      end
   end

   // Core model: answers each issue strobe with aes_done after core_lat cycles
   initial forever begin
      @(negedge clk);
      if (aes_ready && core_auto && !reset) begin
         repeat (core_lat) @(posedge clk);
         #1 aes_done = 1'b1;
         @(posedge clk);
         #1 aes_done = 1'b0;
      end
   end

   task automatic send_byte(input logic [7:0] d, input bit l);
      int t = 0;
      s_data = d;
      s_last = l;
      s_valid = 1'b1;
      @(negedge clk);
      while (!s_ready && t < 2000) begin
         @(negedge clk);
         t++;
      end
      if (!s_ready) begin
         checks++;
         failures++;
         $display("FAIL accept_timeout actual=%0d required=<2000", t);
      end
      @(posedge clk);
      #1;
      s_valid = 1'b0;
      s_last = 1'b0;
   endtask

   task automatic push_model(input bit enc);
      int n = msg.size();
      int nb = 0;
      for (int i = 0; i < n; i += 16) begin
         exp_t e;
         int r = (n - i < 16) ? n - i : 16;
         for (int j = 0; j < 16; j++)
            if (j < r) e.blk[127-8*j -: 8] = msg[i+j];
            else e.blk[127-8*j -: 8] = enc ? 8'(16 - r) : 8'h00;
         e.k = mkey;
         e.enc = enc;
         e.cnt = 16'(nb + 1);
         e.perr = !enc && r < 16;
         e.last = (i + 16 >= n) && !(enc && r == 16);
         exp_q.push_back(e);
         nb++;
      end
      if (enc && n % 16 == 0) begin
         exp_t p;
         p.blk = {16{8'h10}};
         p.k = mkey;
         p.enc = 1'b1;
         p.cnt = 16'(nb + 1);
         p.perr = 1'b0;
         p.last = 1'b1;
         exp_q.push_back(p);
      end
   endtask

   task automatic run_msg(input bit enc, input bit do_key, input logic [127:0] k,
                          input int kl_at, input logic [127:0] k2, input bit wait_done);
      int n = msg.size();
      int t = 0;
      if (do_key) begin
         key = k;
         key_load = 1'b1;
         @(posedge clk);
         #1 key_load = 1'b0;
         mkey = k;
      end
      push_model(enc);
      md_exp++;
      encrypt = enc;
      for (int i = 0; i < n; i++) begin
         if (i == kl_at) begin
            key = k2;
            key_load = 1'b1;
            @(posedge clk);
            #1 key_load = 1'b0;
         end
         send_byte(msg[i], i == n - 1);
         if (i == 0) encrypt = ~enc;
         repeat ($urandom_range(0, 1)) begin
            @(posedge clk);
            #1;
         end
      end
      if (wait_done) begin
         while (md_cnt < md_exp && t < 5000) begin
            @(negedge clk);
            t++;
         end
         chk("msg_done_count", md_cnt, md_exp);
         @(posedge clk);
         #1;
      end
   endtask

   localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] K2 = 128'hfedcba9876543210f0e1d2c3b4a59687;

   initial begin
      int t;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_s_ready", s_ready, 0);
      chk("reset_aes_in", aes_in, 0);
      chk("reset_blk_count", blk_count, 0);
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("post_reset_s_ready", s_ready, 1);
      @(posedge clk);
      #1;
      msg.delete();
      for (int i = 0; i < 16; i++) msg.push_back(8'(i));
      run_msg(1, 1, K1, -1, '0, 1);
      msg.delete();
      repeat (5) msg.push_back(8'hAA);
      run_msg(1, 0, '0, -1, '0, 1);
      msg.delete();
      msg.push_back(8'h11);
      msg.push_back(8'h22);
      msg.push_back(8'h33);
      run_msg(0, 0, '0, -1, '0, 1);
      core_lat = 20;
      msg.delete();
      repeat (32) msg.push_back(8'($urandom));
      run_msg(1, 0, '0, -1, '0, 1);
      core_lat = 2;
      msg.delete();
      repeat (10) msg.push_back(8'($urandom));
      run_msg(1, 1, K1, 4, K2, 1);
      msg.delete();
      repeat (7) msg.push_back(8'($urandom));
      run_msg(0, 1, K2, -1, '0, 1);
      for (int m = 0; m < 8; m++) begin
         int len = $urandom_range(1, 40);
         core_lat = $urandom_range(1, 4);
         msg.delete();
         repeat (len) msg.push_back(8'($urandom));
         run_msg(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 {$urandom, $urandom, $urandom, $urandom}, -1, '0, 1);
      end
      core_auto = 0;
      msg.delete();
      repeat (16) msg.push_back(8'($urandom));
      run_msg(1, 0, '0, -1, '0, 0);
      t = 0;
      while (!busy && t < 100) begin
         @(negedge clk);
         t++;
      end
      chk("reached_wait", busy, 1);
      repeat (3) @(posedge clk);
      #1 reset = 1'b1;
      @(negedge clk);
      chk("rst_wait_s_ready", s_ready, 0);
      @(negedge clk);
      chk("rst_wait_aes_in", aes_in, 0);
      chk("rst_wait_aes_key", aes_key, 0);
      chk("rst_wait_aes_encrypt", aes_encrypt, 0);
      chk("rst_wait_aes_ready", aes_ready, 0);
      chk("rst_wait_msg_done", msg_done, 0);
      chk("rst_wait_pad_err", pad_err, 0);
      chk("rst_wait_blk_count", blk_count, 0);
      @(posedge clk);
      #1 reset = 1'b0;
      exp_q.delete();
      expect_md = 0;
      busy = 0;
      md_exp = md_cnt;
      mkey = '0;
      aes_done = 1'b1;
      @(posedge clk);
      #1 aes_done = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      chk("stale_done_no_msg_done", md_cnt, md_exp);
      @(negedge clk);
      chk("after_stale_s_ready", s_ready, 1);
      @(posedge clk);
      #1;
      core_auto = 1;
      msg.delete();
      repeat (16) msg.push_back(8'($urandom));
      run_msg(0, 0, '0, -1, '0, 1);
      repeat (5) @(posedge clk);
      chk("scoreboard_empty", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
